seg_bin_capture: RTL and testbench
==================================

// Module: seg_bin_capture
// PURPOSE
//  Inverse of the hex-to-7-segment decoder: samples a multiplexed 7-segment display bus
//  (segment pattern + one-hot digit enable), filters glitches and maps each stable pattern
//  back to its 4-bit value. Assembles one DIGITS-wide hex word per frame and offers it on a
//  valid/ready interface. Used as a loopback checker behind the display driver.
// PARAMETERS
//  DIGITS         4   number of multiplexed digits (digit i -> out_data[4i+3:4i])
//  STABLE_CYCLES  4   consecutive identical samples required to accept a digit (>=2)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  seg_in     in   7          segment pattern {g,f,e,d,c,b,a}, active-low (0 = lit)
//  dig_en     in   DIGITS     digit select, active-high, one-hot when valid
//  out_data   out  4*DIGITS   decoded word
//  out_err    out  DIGITS     per-digit flag: pattern not one of the 16 hex glyphs
//  out_valid  out  1          frame available
//  out_ready  in   1          consumer accepts frame
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, out_err=0, capture mask=0,
//    stability counter=0, input registers=0, FSM=COLLECT. Partial frames discarded.
//  - Input stage: {dig_en,seg_in} registered each edge (one sync stage).
//  - Stability: counter resets to 1 when registered value differs from previous one,
//    else increments, saturating at STABLE_CYCLES. Digit captured on the edge where the
//    counter reaches STABLE_CYCLES; one capture per stable period (no re-capture until a change).
//  - dig_en zero or not one-hot: never captured; counter still tracks the value.
//  - Decode (active-low, hex): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8
//    10->9 08->A 03->B 46->C 21->D 06->E 0E->F. Any other pattern: nibble=0, err bit=1.
//  - Capture writes nibble+err into slot of the selected digit, sets its mask bit;
//    recapturing an already-masked digit overwrites it (latest wins).
//  - FSM COLLECT: when a capture completes the mask (all ones), data/err copied to outputs,
//    out_valid=1 from the next cycle, FSM->PRESENT.
//  - FSM PRESENT: out_data/out_err/out_valid held stable; captures ignored (dropped),
//    stability counter keeps running. On out_valid&&out_ready edge: out_valid=0, mask=0,
//    FSM->COLLECT. A digit whose stable period spans the handshake is not captured
//    until its value changes.
//  - Latency: value presented at input before edge E0 is captured at edge
//    E0+STABLE_CYCLES (1 sync + STABLE_CYCLES-1 compare).
//  - out_ready ignored in COLLECT; out_valid never drops without handshake or reset.
// TESTING
//  1. Scan digits 3..0 with 79,24,30,19, 8 cycles each, out_ready=1 -> out_data=16'h1234,
//     out_err=0, out_valid high exactly 1 cycle.
//  2. Sweep all 16 glyphs on digit 0 (digits 3..1 = 00) one frame each -> out_data=16'h888X
//     with X matching glyph, out_err=0 every frame.
//  3. Digit 2 shows 7F (blank) -> out_err=4'b0100, out_data[11:8]=0, others correct.
//  4. Digit 1 glitch held 3 cycles then real value 8 cycles (STABLE_CYCLES=4) ->
//     glitch never captured; dig_en=4'b0011 for 10 cycles -> no capture.
//  5. out_ready=0 for 20 cycles after valid, new patterns on bus -> out_data unchanged,
//     out_valid held; after ready pulse next frame built only from new captures.
//  6. rst_n pulled low after 2 of 4 digits captured -> outputs 0 asynchronously; after
//     release a full fresh scan is required before out_valid.

Source files
------------

// File: rtl/seg_bin_capture.sv
// Loopback checker for a multiplexed 7-segment bus: debounces each digit, decodes the
// active-low glyph back to hex and presents one DIGITS-wide word per frame on valid/ready.
module seg_bin_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned IW = DIGITS + 7;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {
        COLLECT,
        PRESENT
    } state_t;

    state_t                state_q;
    logic [IW-1:0]         in_q;
    logic [IW-1:0]         prev_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  blk_q;
    logic                  blk_d;
    logic [DIGITS-1:0]     mask_q;
    logic [4*DIGITS-1:0]   slot_data_q;
    logic [DIGITS-1:0]     slot_err_q;

    logic [DIGITS-1:0]     sel;
    logic                  same;
    logic                  onehot;
    logic                  handshake;
    logic                  cap;
    logic [4:0]            dec;
    logic [DIGITS-1:0]     wr_mask;
    logic [4*DIGITS-1:0]   wr_data;
    logic [DIGITS-1:0]     wr_err;

    // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    assign sel       = in_q[IW-1:7];
    assign same      = (in_q == prev_q);
    assign onehot    = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign handshake = (state_q == PRESENT) && out_ready;
    assign dec       = seg_decode(in_q[6:0]);
    // The counter saturates, so this fires exactly once per stable period.
    assign cap       = same && (cnt_q == CW'(STABLE_CYCLES - 1)) && onehot && !blk_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A stable period already running at the handshake stays blocked until the value changes.
    always_comb begin
        blk_d = blk_q;
        if (!same) begin
            blk_d = 1'b0;
        end else if (handshake) begin
            blk_d = 1'b1;
        end
    end

    always_comb begin
        wr_mask = mask_q | sel;
        wr_data = slot_data_q;
        wr_err  = slot_err_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sel[i]) begin
                wr_data[4*i +: 4] = dec[3:0];
                wr_err[i]         = dec[4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            in_q        <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            blk_q       <= 1'b0;
            mask_q      <= '0;
            slot_data_q <= '0;
            slot_err_q  <= '0;
            out_data    <= '0;
            out_err     <= '0;
            out_valid   <= 1'b0;
        end else begin
            in_q   <= {dig_en, seg_in};
            prev_q <= in_q;
            cnt_q  <= cnt_d;
            blk_q  <= blk_d;
            case (state_q)
                COLLECT: begin
                    if (cap) begin
                        slot_data_q <= wr_data;
                        slot_err_q  <= wr_err;
                        mask_q      <= wr_mask;
                        if (&wr_mask) begin
                            out_data  <= wr_data;
                            out_err   <= wr_err;
                            out_valid <= 1'b1;
                            state_q   <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mask_q    <= '0;
                        state_q   <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bin_capture.sv
// Directed bench for seg_bin_capture: expected frames are queued as the bus is driven and
// compared when the DUT hands a frame over.
module tb_seg_bin_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] out_data;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready;

    int          checks = 0;
    int          errors = 0;
    int          vcnt = 0;
    logic [19:0] exp_q[$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_bin_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_en    (dig_en),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe at the falling edge with the inputs for the coming rising edge, then advance.
    task automatic cyc();
        logic [19:0] e;
        if (out_valid === 1'b1) vcnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("frame_data", out_data, e[15:0]);
                chk("frame_err", out_err, e[19:16]);
            end
        end
        @(negedge clk);
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        dig_en = 4'(1 << d);
        seg_in = s;
        repeat (n) cyc();
    endtask

    task automatic scan(input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0);
        show(3, s3, 8);
        show(2, s2, 8);
        show(1, s1, 8);
        show(0, s0, 8);
    endtask

    task automatic idle(input int n);
        dig_en = '0;
        seg_in = '1;
        repeat (n) cyc();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            cyc();
            k++;
        end
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        seg_in    = '1;
        dig_en    = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_err", out_err, 0);
        rst_n = 1'b1;
        idle(3);

        // 1: basic scan, valid exactly one cycle with ready high
        vcnt = 0;
        exp_q.push_back({4'h0, 16'h1234});
        scan(7'h79, 7'h24, 7'h30, 7'h19);
        idle(4);
        drain("t1");
        chk("t1_valid_cycles", vcnt, 1);

        // 2: all glyphs on digit 0
        for (int g = 0; g < 16; g++) begin
            exp_q.push_back({4'h0, 12'h888, 4'(g)});
            scan(7'h00, 7'h00, 7'h00, glyph[g]);
        end
        idle(4);
        drain("t2");

        // 3: blank digit flagged as error
        exp_q.push_back({4'b0100, 16'h1023});
        scan(7'h79, 7'h7F, 7'h24, 7'h30);
        idle(4);
        drain("t3");

        // 4: short glitch and non-one-hot enable are never captured
        exp_q.push_back({4'h0, 16'h0024});
        show(3, 7'h40, 8);
        show(2, 7'h40, 8);
        show(1, 7'h79, 3);
        show(1, 7'h24, 8);
        dig_en = 4'b0011;
        seg_in = 7'h12;
        repeat (10) cyc();
        chk("t4_no_early_valid", out_valid, 0);
        show(0, 7'h19, 8);
        idle(4);
        drain("t4");

        // 5: backpressure holds the frame; captures while presenting are dropped
        out_ready = 1'b0;
        exp_q.push_back({4'h0, 16'h5678});
        scan(7'h12, 7'h02, 7'h78, 7'h00);
        show(3, 7'h10, 8);
        show(2, 7'h08, 8);
        show(1, 7'h03, 8);
        chk("t5_valid_held", out_valid, 1);
        chk("t5_data_held", out_data, 16'h5678);
        chk("t5_err_held", out_err, 0);
        out_ready = 1'b1;
        cyc();
        chk("t5_handshake_pop", exp_q.size(), 0);
        exp_q.push_back({4'h0, 16'hCDEF});
        scan(7'h46, 7'h21, 7'h06, 7'h0E);
        idle(4);
        drain("t5");

        // 6: asynchronous reset while presenting, then mid-frame
        out_ready = 1'b0;
        scan(7'h79, 7'h24, 7'h30, 7'h19);
        chk("t6_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_data", out_data, 0);
        chk("t6_async_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        show(3, 7'h40, 8);
        show(2, 7'h40, 8);
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        show(1, 7'h79, 8);
        show(0, 7'h79, 8);
        idle(10);
        chk("t6_partial_discarded", vcnt, 0);
        exp_q.push_back({4'h0, 16'h0011});
        scan(7'h40, 7'h40, 7'h79, 7'h79);
        idle(4);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
